// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, issues single-outstanding word reads to imem and
// queues returned instructions in a small FIFO for the decoder.
module instr_fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int unsigned       DEPTH    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o
);

  localparam int unsigned       PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]    DEPTH_C = DEPTH[CNT_W:0];
  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'd4};

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       instr_mem_d [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d [DEPTH];

  logic              valid_s;
  logic              pop_s;
  logic              push_s;
  logic              req_s;
  logic [CNT_W:0]    credit_s;

  // Handshake and credit-based issue decision
  always_comb begin
    valid_s  = (count_q != {CNT_W{1'b0}});
    pop_s    = valid_s & instr_ready_i & ~redirect_i;
    push_s   = inflight_q & ~redirect_i;
    // Slots already promised to the outstanding read count against free space.
    credit_s = {1'b0, count_q} - {{CNT_W{1'b0}}, pop_s} + {{CNT_W{1'b0}}, inflight_q};
    req_s    = ~rst_i & ~redirect_i & (credit_s < DEPTH_C);
  end

  // Next-state: PC, outstanding-read tracking and FIFO bookkeeping
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;
    instr_mem_d   = instr_mem_q;
    pc_mem_d      = pc_mem_q;

    if (redirect_i) begin
      pc_d       = {redirect_pc_i[ADDR_W-1:2], 2'b00};
      inflight_d = 1'b0;
      wptr_d     = {PTR_W{1'b0}};
      rptr_d     = {PTR_W{1'b0}};
      count_d    = {CNT_W{1'b0}};
    end else begin
      inflight_d = req_s;
      if (req_s) begin
        pc_d          = pc_q + PC_STEP;
        inflight_pc_d = pc_q;
      end else begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
      end

      if (push_s) begin
        instr_mem_d[wptr_q] = imem_rdata_i;
        pc_mem_d[wptr_q]    = inflight_pc_q;
        wptr_d              = wptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        wptr_d = wptr_q;
      end

      if (pop_s) begin
        rptr_d = rptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        rptr_d = rptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= {ADDR_W{1'b0}};
      wptr_q        <= {PTR_W{1'b0}};
      rptr_q        <= {PTR_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= 32'h0000_0000;
        pc_mem_q[i]    <= {ADDR_W{1'b0}};
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      instr_mem_q   <= instr_mem_d;
      pc_mem_q      <= pc_mem_d;
    end
  end

  // Decoder-facing outputs; zeroed while the queue is empty
  always_comb begin
    imem_req_o    = req_s;
    imem_addr_o   = pc_q;
    instr_valid_o = valid_s;
    if (valid_s) begin
      instr_o    = instr_mem_q[rptr_q];
      pc_o       = pc_mem_q[rptr_q];
      pc_plus4_o = pc_mem_q[rptr_q] + PC_STEP;
    end else begin
      instr_o    = 32'h0000_0000;
      pc_o       = {ADDR_W{1'b0}};
      pc_plus4_o = {ADDR_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed + random bench for instr_fetch_queue, checked every cycle against a
// transaction-level queue model of the fetch path.
module tb_instr_fetch_queue;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  instr_fetch_queue #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:2], a[31:8] ^ 24'hC3A55A, 2'b10};
  endfunction

  // imem: one-cycle read; not reset, so a stale word can sit on the bus
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr  = 32'h0;
  always @(posedge clk_i) begin
    mem_valid <= imem_req_o;
    mem_addr  <= imem_addr_o;
  end
  assign imem_rdata_i = mem_valid ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_inf_pc;
  bit          m_inf;
  bit          e_pop, e_req, c_redir;
  logic [31:0] c_rpc;
  int          total = 0;
  int          bad   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_inf    = 1'b0;
    m_inf_pc = 32'h0;
    m_pc     = RESET_PC;
  endtask

  task automatic apply(input bit rdy, input bit rd, input logic [31:0] rpc);
    int n;
    instr_ready_i = rdy;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    #1;
    n       = m_q.size();
    e_pop   = (n > 0) && rdy && !rd;
    e_req   = !rd && ((n - (e_pop ? 1 : 0) + (m_inf ? 1 : 0)) < DEPTH);
    c_redir = rd;
    c_rpc   = rpc;
    check32("req",   {31'h0, imem_req_o},    {31'h0, e_req});
    check32("addr",  imem_addr_o,            m_pc);
    check32("valid", {31'h0, instr_valid_o}, (n > 0) ? 32'h1 : 32'h0);
    check32("instr", instr_o,    (n > 0) ? m_q[0].instr : 32'h0);
    check32("pc",    pc_o,       (n > 0) ? m_q[0].pc : 32'h0);
    check32("pc4",   pc_plus4_o, (n > 0) ? m_q[0].pc + 32'd4 : 32'h0);
  endtask

  task automatic drive(input bit rdy, input bit rd, input logic [31:0] rpc);
    @(negedge clk_i);
    apply(rdy, rd, rpc);
  endtask

  task automatic advance();
    ent_t e;
    @(posedge clk_i);
    if (c_redir) begin
      m_q.delete();
      m_inf = 1'b0;
      m_pc  = {c_rpc[31:2], 2'b00};
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (m_inf) begin
        e.pc    = m_inf_pc;
        e.instr = mem_word(m_inf_pc);
        m_q.push_back(e);
      end
      m_inf = e_req;
      if (e_req) begin
        m_inf_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_req"},   {31'h0, imem_req_o},    32'h0);
    check32({tag, "_addr"},  imem_addr_o,            RESET_PC);
    check32({tag, "_valid"}, {31'h0, instr_valid_o}, 32'h0);
    check32({tag, "_instr"}, instr_o,                32'h0);
    check32({tag, "_pc"},    pc_o,                   32'h0);
    check32({tag, "_pc4"},   pc_plus4_o,             32'h0);
  endtask

  initial begin
    rst_i         = 1'b1;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("rst");
    rst_i = 1'b0;

    // Streaming from reset across the 32-bit PC wrap
    apply(1'b1, 1'b0, 32'h0);
    check32("lit_c0_req",  {31'h0, imem_req_o}, 32'h1);
    check32("lit_c0_addr", imem_addr_o, 32'hFFFF_FFF8);
    advance();
    drive(1'b1, 1'b0, 32'h0);
    check32("lit_c1_addr",  imem_addr_o, 32'hFFFF_FFFC);
    check32("lit_c1_valid", {31'h0, instr_valid_o}, 32'h0);
    advance();
    drive(1'b1, 1'b0, 32'h0);
    check32("lit_c2_valid", {31'h0, instr_valid_o}, 32'h1);
    check32("lit_c2_pc",    pc_o,        32'hFFFF_FFF8);
    check32("lit_c2_pc4",   pc_plus4_o,  32'hFFFF_FFFC);
    check32("lit_c2_addr",  imem_addr_o, 32'h0000_0000);
    advance();
    drive(1'b1, 1'b0, 32'h0);
    check32("lit_c3_pc",  pc_o,       32'hFFFF_FFFC);
    check32("lit_c3_pc4", pc_plus4_o, 32'h0000_0000);
    advance();
    drive(1'b1, 1'b0, 32'h0);
    check32("lit_c4_pc",    pc_o,       32'h0000_0000);
    check32("lit_c4_pc4",   pc_plus4_o, 32'h0000_0004);
    check32("lit_c4_instr", instr_o,    32'h030E_956A);
    advance();
    repeat (4) begin drive(1'b1, 1'b0, 32'h0); advance(); end

    // Back-pressure: queue fills to DEPTH and fetch stops
    repeat (10) begin drive(1'b0, 1'b0, 32'h0); advance(); end
    drive(1'b0, 1'b0, 32'h0);
    check32("lit_full_req",   {31'h0, imem_req_o}, 32'h0);
    check32("lit_full_valid", {31'h0, instr_valid_o}, 32'h1);
    check32("lit_full_head",  pc_o, 32'h0000_0014);
    check32("lit_full_depth", m_q.size(), 32'd4);
    advance();

    // One pop leaves a read in flight, then redirect with a non-empty queue
    drive(1'b1, 1'b0, 32'h0);
    check32("lit_refill_addr", imem_addr_o, 32'h0000_0024);
    advance();
    drive(1'b0, 1'b1, 32'h0000_0103);
    check32("lit_r0_req", {31'h0, imem_req_o}, 32'h0);
    advance();
    drive(1'b0, 1'b0, 32'h0);
    check32("lit_r1_valid", {31'h0, instr_valid_o}, 32'h0);
    check32("lit_r1_req",   {31'h0, imem_req_o}, 32'h1);
    check32("lit_r1_addr",  imem_addr_o, 32'h0000_0100);
    advance();
    drive(1'b0, 1'b0, 32'h0);
    check32("lit_r2_valid", {31'h0, instr_valid_o}, 32'h0);
    advance();
    drive(1'b0, 1'b0, 32'h0);
    check32("lit_r3_valid", {31'h0, instr_valid_o}, 32'h1);
    check32("lit_r3_pc",    pc_o,    32'h0000_0100);
    check32("lit_r3_instr", instr_o, 32'h030E_956E);
    advance();
    repeat (8) begin drive(1'b1, 1'b0, 32'h0); advance(); end

    // Redirect coinciding with ready: the head is dropped, not re-presented
    drive(1'b1, 1'b1, 32'h0000_0200);
    check32("lit_rp_pre_valid", {31'h0, instr_valid_o}, 32'h1);
    advance();
    drive(1'b1, 1'b0, 32'h0);
    check32("lit_rp_post_valid", {31'h0, instr_valid_o}, 32'h0);
    advance();
    repeat (4) begin drive(1'b1, 1'b0, 32'h0); advance(); end

    // Back-to-back redirects: the last target wins
    drive(1'b1, 1'b1, 32'h0000_0300); advance();
    drive(1'b1, 1'b1, 32'h0000_0406); advance();
    drive(1'b1, 1'b0, 32'h0);
    check32("lit_b2b_addr", imem_addr_o, 32'h0000_0404);
    check32("lit_b2b_req",  {31'h0, imem_req_o}, 32'h1);
    advance();
    repeat (4) begin drive(1'b1, 1'b0, 32'h0); advance(); end

    // Short reset pulse between edges while a response is still on the bus
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    #1;
    rst_i = 1'b0;
    apply(1'b1, 1'b0, 32'h0);
    advance();
    drive(1'b1, 1'b0, 32'h0);
    check32("lit_postrst_valid", {31'h0, instr_valid_o}, 32'h0);
    advance();
    repeat (4) begin drive(1'b1, 1'b0, 32'h0); advance(); end

    // Random ready / redirect traffic
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000F);
      drive($urandom_range(9) < 7, $urandom_range(19) == 0, tgt);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
